// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one combinational ALU between the execute stage
// (requester 0) and the helper port (requester 1). Round-robin grant, one
// transaction in flight, fixed 2-cycle accept-to-response latency.
// Optional build macro: ALU_ARB_OP_CHECK_EN -- flags op codes above 4'b0110
// as illegal, steers the ALU to 4'b1001 and returns data=0, zero=0, err=1.
module alu_share_arbiter #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  // requester 0 (execute stage)
  input  logic                  req0_valid_i,
  output logic                  req0_ready_o,
  input  logic [3:0]            req0_op_i,
  input  logic [DATA_WIDTH-1:0] req0_a_i,
  input  logic [DATA_WIDTH-1:0] req0_b_i,
  input  logic [4:0]            req0_shamt_i,
  output logic                  rsp0_valid_o,
  input  logic                  rsp0_ready_i,
  output logic [DATA_WIDTH-1:0] rsp0_data_o,
  output logic                  rsp0_zero_o,
  output logic                  rsp0_err_o,
  // requester 1 (helper port)
  input  logic                  req1_valid_i,
  output logic                  req1_ready_o,
  input  logic [3:0]            req1_op_i,
  input  logic [DATA_WIDTH-1:0] req1_a_i,
  input  logic [DATA_WIDTH-1:0] req1_b_i,
  input  logic [4:0]            req1_shamt_i,
  output logic                  rsp1_valid_o,
  input  logic                  rsp1_ready_i,
  output logic [DATA_WIDTH-1:0] rsp1_data_o,
  output logic                  rsp1_zero_o,
  output logic                  rsp1_err_o,
  // shared ALU
  output logic [3:0]            alu_operation_o,
  output logic [DATA_WIDTH-1:0] alu_a_o,
  output logic [DATA_WIDTH-1:0] alu_b_o,
  output logic [4:0]            alu_shamt_o,
  input  logic [DATA_WIDTH-1:0] alu_result_i,
  input  logic                  alu_zero_i
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]            state_r;
  logic                  prio_r;
  logic                  owner_r;
  logic [3:0]            op_r;
  logic [DATA_WIDTH-1:0] a_r;
  logic [DATA_WIDTH-1:0] b_r;
  logic [4:0]            shamt_r;
  logic [DATA_WIDTH-1:0] data_r;
  logic                  zero_r;
  logic                  err_r;

  logic                  grant;
  logic                  accept;
  logic                  rsp_done;
  logic [3:0]            sel_op;
  logic [DATA_WIDTH-1:0] sel_a;
  logic [DATA_WIDTH-1:0] sel_b;
  logic [4:0]            sel_shamt;
  logic                  sel_illegal;
  logic [3:0]            issue_op;

  // Round-robin grant: a lone requester wins, ties go to prio_r.
  always_comb begin
    grant = 1'b0;
    if (req0_valid_i && req1_valid_i) grant = prio_r;
    else if (req1_valid_i)            grant = 1'b1;
  end

  assign accept   = (state_r == IDLE) && (req0_valid_i || req1_valid_i);
  assign rsp_done = (state_r == RESP) && (owner_r ? rsp1_ready_i : rsp0_ready_i);

  assign req0_ready_o = (state_r == IDLE) && !grant && req0_valid_i;
  assign req1_ready_o = (state_r == IDLE) &&  grant && req1_valid_i;

  // Mux the granted request onto the issue path.
  always_comb begin
    sel_op    = grant ? req1_op_i    : req0_op_i;
    sel_a     = grant ? req1_a_i     : req0_a_i;
    sel_b     = grant ? req1_b_i     : req0_b_i;
    sel_shamt = grant ? req1_shamt_i : req0_shamt_i;
  end

  // Illegal-op screening; decided at accept so the substitute op is already
  // on alu_operation_o during EXEC.
  always_comb begin
`ifdef ALU_ARB_OP_CHECK_EN
    sel_illegal = (sel_op > 4'd6);
    issue_op    = sel_illegal ? 4'b1001 : sel_op;
`else
    sel_illegal = 1'b0;
    issue_op    = sel_op;
`endif
  end

  // Sequencer: IDLE accept -> EXEC capture -> RESP handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      prio_r  <= 1'b0;
      owner_r <= 1'b0;
      op_r    <= '0;
      a_r     <= '0;
      b_r     <= '0;
      shamt_r <= '0;
      data_r  <= '0;
      zero_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept) begin
            op_r    <= issue_op;
            a_r     <= sel_a;
            b_r     <= sel_b;
            shamt_r <= sel_shamt;
            err_r   <= sel_illegal;
            owner_r <= grant;
            prio_r  <= ~grant;
            state_r <= EXEC;
          end
        end
        EXEC: begin
          data_r  <= err_r ? '0 : alu_result_i;
          zero_r  <= err_r ? 1'b0 : alu_zero_i;
          state_r <= RESP;
        end
        RESP: begin
          if (rsp_done) state_r <= IDLE;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign alu_operation_o = op_r;
  assign alu_a_o         = a_r;
  assign alu_b_o         = b_r;
  assign alu_shamt_o     = shamt_r;

  // Response outputs are visible only to the owner and only while in RESP.
  always_comb begin
    rsp0_valid_o = (state_r == RESP) && !owner_r;
    rsp1_valid_o = (state_r == RESP) &&  owner_r;
    rsp0_data_o  = rsp0_valid_o ? data_r : '0;
    rsp0_zero_o  = rsp0_valid_o && zero_r;
    rsp0_err_o   = rsp0_valid_o && err_r;
    rsp1_data_o  = rsp1_valid_o ? data_r : '0;
    rsp1_zero_o  = rsp1_valid_o && zero_r;
    rsp1_err_o   = rsp1_valid_o && err_r;
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural ALU attached.
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid_i, req0_ready_o, rsp0_valid_o, rsp0_ready_i, rsp0_zero_o, rsp0_err_o;
  logic [3:0]  req0_op_i;
  logic [31:0] req0_a_i, req0_b_i, rsp0_data_o;
  logic [4:0]  req0_shamt_i;
  logic        req1_valid_i, req1_ready_o, rsp1_valid_o, rsp1_ready_i, rsp1_zero_o, rsp1_err_o;
  logic [3:0]  req1_op_i;
  logic [31:0] req1_a_i, req1_b_i, rsp1_data_o;
  logic [4:0]  req1_shamt_i;
  logic [3:0]  alu_operation_o;
  logic [31:0] alu_a_o, alu_b_o, alu_result_i;
  logic [4:0]  alu_shamt_o;
  logic        alu_zero_i;

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o), .req0_op_i(req0_op_i),
    .req0_a_i(req0_a_i), .req0_b_i(req0_b_i), .req0_shamt_i(req0_shamt_i),
    .rsp0_valid_o(rsp0_valid_o), .rsp0_ready_i(rsp0_ready_i), .rsp0_data_o(rsp0_data_o),
    .rsp0_zero_o(rsp0_zero_o), .rsp0_err_o(rsp0_err_o),
    .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o), .req1_op_i(req1_op_i),
    .req1_a_i(req1_a_i), .req1_b_i(req1_b_i), .req1_shamt_i(req1_shamt_i),
    .rsp1_valid_o(rsp1_valid_o), .rsp1_ready_i(rsp1_ready_i), .rsp1_data_o(rsp1_data_o),
    .rsp1_zero_o(rsp1_zero_o), .rsp1_err_o(rsp1_err_o),
    .alu_operation_o(alu_operation_o), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o),
    .alu_shamt_o(alu_shamt_o), .alu_result_i(alu_result_i), .alu_zero_i(alu_zero_i)
  );

  // Behavioural ALU; unknown codes return a non-zero marker.
  always_comb begin
    case (alu_operation_o)
      4'b0000: alu_result_i = alu_b_o;
      4'b0001: alu_result_i = alu_a_o | alu_b_o;
      4'b0010: alu_result_i = alu_a_o << alu_shamt_o;
      4'b0011: alu_result_i = alu_a_o + alu_b_o;
      4'b0100: alu_result_i = alu_a_o >> alu_shamt_o;
      4'b0101: alu_result_i = alu_a_o - alu_b_o;
      4'b0110: alu_result_i = alu_a_o & alu_b_o;
      default: alu_result_i = 32'hDEAD_BEEF;
    endcase
    alu_zero_i = (alu_result_i == 32'd0);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req0_valid_i = 0; req0_op_i = 0; req0_a_i = 0; req0_b_i = 0; req0_shamt_i = 0; rsp0_ready_i = 0;
    req1_valid_i = 0; req1_op_i = 0; req1_a_i = 0; req1_b_i = 0; req1_shamt_i = 0; rsp1_ready_i = 0;
    step();
    step();
    reset = 1'b0;

    // Reset state
    check("rst_ready0", req0_ready_o, 0);
    check("rst_rsp0_valid", rsp0_valid_o, 0);
    check("rst_rsp1_valid", rsp1_valid_o, 0);
    check("rst_alu_op", alu_operation_o, 0);
    check("rst_alu_a", alu_a_o, 0);
    check("rst_rsp0_data", rsp0_data_o, 0);

    // Single add from req0: 5 + 7
    req0_valid_i = 1; req0_op_i = 4'b0011; req0_a_i = 5; req0_b_i = 7;
    settle();
    check("add_ready0", req0_ready_o, 1);
    step();
    req0_valid_i = 0; req0_a_i = 32'hFFFF_FFFF;
    settle();
    check("add_exec_op", alu_operation_o, 4'b0011);
    check("add_exec_a", alu_a_o, 5);
    check("add_exec_b", alu_b_o, 7);
    check("add_exec_rsp_valid", rsp0_valid_o, 0);
    step();
    check("add_rsp_valid", rsp0_valid_o, 1);
    check("add_rsp_data", rsp0_data_o, 12);
    check("add_rsp_zero", rsp0_zero_o, 0);
    check("add_rsp_err", rsp0_err_o, 0);
    check("add_rsp1_quiet", rsp1_valid_o, 0);
    rsp0_ready_i = 1;
    step();
    rsp0_ready_i = 0;
    check("add_back_idle", rsp0_valid_o, 0);
    check("add_alu_hold", alu_operation_o, 4'b0011);

    // Dual request after reset, plus response backpressure
    do_reset();
    req0_valid_i = 1; req0_op_i = 4'b0011; req0_a_i = 1; req0_b_i = 1;
    req1_valid_i = 1; req1_op_i = 4'b0101; req1_a_i = 9; req1_b_i = 9;
    settle();
    check("dual_ready0", req0_ready_o, 1);
    check("dual_ready1", req1_ready_o, 0);
    step();
    req0_valid_i = 0;
    settle();
    check("dual_exec_ready1", req1_ready_o, 0);
    step();
    check("dual_rsp0_valid", rsp0_valid_o, 1);
    check("dual_rsp0_data", rsp0_data_o, 2);
    for (int i = 0; i < 4; i++) begin
      step();
      check("bp_rsp0_valid", rsp0_valid_o, 1);
      check("bp_rsp0_data", rsp0_data_o, 2);
      check("bp_rsp0_zero", rsp0_zero_o, 0);
      check("bp_ready1", req1_ready_o, 0);
    end
    rsp0_ready_i = 1;
    step();
    rsp0_ready_i = 0;
    settle();
    check("bp_idle_ready1", req1_ready_o, 1);
    step();
    req1_valid_i = 0;
    settle();
    check("sub_exec_op", alu_operation_o, 4'b0101);
    step();
    check("sub_rsp1_valid", rsp1_valid_o, 1);
    check("sub_rsp1_data", rsp1_data_o, 0);
    check("sub_rsp1_zero", rsp1_zero_o, 1);
    check("sub_rsp0_quiet", rsp0_valid_o, 0);
    check("sub_rsp0_data", rsp0_data_o, 0);
    rsp1_ready_i = 1;
    step();
    rsp1_ready_i = 0;

    // Illegal op on req1
    req1_valid_i = 1; req1_op_i = 4'b1111; req1_a_i = 3; req1_b_i = 4;
    settle();
    check("ill_ready1", req1_ready_o, 1);
    step();
    req1_valid_i = 0;
    settle();
`ifdef ALU_ARB_OP_CHECK_EN
    check("ill_exec_op", alu_operation_o, 4'b1001);
    step();
    check("ill_rsp1_valid", rsp1_valid_o, 1);
    check("ill_rsp1_data", rsp1_data_o, 0);
    check("ill_rsp1_zero", rsp1_zero_o, 0);
    check("ill_rsp1_err", rsp1_err_o, 1);
`else
    check("ill_exec_op", alu_operation_o, 4'b1111);
    step();
    check("ill_rsp1_valid", rsp1_valid_o, 1);
    check("ill_rsp1_data", rsp1_data_o, 32'hDEAD_BEEF);
    check("ill_rsp1_err", rsp1_err_o, 0);
`endif
    rsp1_ready_i = 1;
    step();
    rsp1_ready_i = 0;

    // Reset during EXEC (req0 accept leaves prio pointing at req1)
    req0_valid_i = 1; req0_op_i = 4'b0001; req0_a_i = 32'h0F0; req0_b_i = 32'h00F;
    step();
    req0_valid_i = 0;
    settle();
    check("rx_exec_op", alu_operation_o, 4'b0001);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rx_rsp0_valid", rsp0_valid_o, 0);
    check("rx_rsp1_valid", rsp1_valid_o, 0);
    check("rx_alu_op", alu_operation_o, 0);
    check("rx_alu_a", alu_a_o, 0);
    check("rx_alu_b", alu_b_o, 0);
    step();
    check("rx_no_late_rsp", rsp0_valid_o, 0);

    // Continuous dual requests: grants alternate 0,1,0,1,0,1
    req0_valid_i = 1; req0_op_i = 4'b0011; req0_a_i = 2; req0_b_i = 3; req0_shamt_i = 0;
    req1_valid_i = 1; req1_op_i = 4'b0010; req1_a_i = 3; req1_b_i = 0; req1_shamt_i = 4;
    rsp0_ready_i = 1; rsp1_ready_i = 1;
    settle();
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) begin
        check("rr_ready0", req0_ready_o, 1);
        check("rr_ready1", req1_ready_o, 0);
      end else begin
        check("rr_ready0", req0_ready_o, 0);
        check("rr_ready1", req1_ready_o, 1);
      end
      step();
      check("rr_exec_rsp0", rsp0_valid_o, 0);
      check("rr_exec_rsp1", rsp1_valid_o, 0);
      check("rr_exec_shamt", alu_shamt_o, (i % 2 == 0) ? 0 : 4);
      step();
      if (i % 2 == 0) begin
        check("rr_rsp0_valid", rsp0_valid_o, 1);
        check("rr_rsp0_data", rsp0_data_o, 5);
      end else begin
        check("rr_rsp1_valid", rsp1_valid_o, 1);
        check("rr_rsp1_data", rsp1_data_o, 48);
      end
      step();
    end
    req0_valid_i = 0; req1_valid_i = 0;
    step();
    check("end_idle_rsp0", rsp0_valid_o, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
